// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_e : arbiter FSM encoding
//   WAIT_W      : width of the per-access wait counter (TIMEOUT range 1..255)
//   STARVE_W    : width of the fetch-starvation counter (STARVE_MAX up to 15)
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_WAIT = 2'd1,
      I_WAIT = 2'd2
   } arb_state_e;

   localparam int WAIT_W   = 8;
   localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for an outstanding memory access.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the count back to zero (has priority over enable)
//   enable     : count one cycle of waiting
//   timeout    : cycle count at which the access is abandoned
//   expired    : count has reached timeout while enabled
module mem_arb_timer
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic [WAIT_W-1:0] timeout,
   output logic              expired
);

   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (clear) begin
         wait_cnt <= '0;
      end else if (enable) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign expired = enable & (wait_cnt == timeout);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM-stage
// load/store path, runs the req/ack handshake and produces pipeline stalls.
//   clk, rst_n          : clock, synchronous active-low reset
//   if_req/if_addr      : fetch request (held until if_ready)
//   if_rdata/if_ready   : fetched word and one-cycle completion pulse
//   m_req/m_we/m_addr/m_wdata/m_be : data access request (held until m_ready)
//   M_flush             : MEM stage flushed this cycle
//   m_rdata/m_ready     : load data and one-cycle completion pulse
//   F_stall/M_stall     : combinational pipeline freeze requests
//   bus_err             : one-cycle pulse when memory never acknowledged
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : registered memory request
//   mem_ack/mem_rdata   : memory completion and read data
//
// state  | meaning
// IDLE   | no access outstanding; arbitrate between fetch and data
// D_WAIT | data access outstanding, waiting for mem_ack or timeout
// I_WAIT | fetch access outstanding, waiting for mem_ack or timeout
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT    = 255,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        m_req,
   input  logic        m_we,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_be,
   input  logic        M_flush,
   output logic [31:0] m_rdata,
   output logic        m_ready,
   output logic        F_stall,
   output logic        M_stall,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   arb_state_e          state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                drop_q, drop_d;

   logic        mem_req_d, mem_we_d;
   logic [31:0] mem_addr_d, mem_wdata_d;
   logic [3:0]  mem_be_d;
   logic [31:0] m_rdata_d, if_rdata_d;
   logic        m_ready_d, if_ready_d, bus_err_d;

   logic in_idle, m_ok, if_ok, starved, turnaround;
   logic data_grant, fetch_grant, expired, timer_clr, dropping;

   assign F_stall = if_req & ~if_ready;
   assign M_stall = m_req & ~m_ready & ~M_flush;

   assign in_idle = (state_q == IDLE);
   assign m_ok    = m_req & ~m_ready & ~M_flush;
   assign if_ok   = if_req & ~if_ready;
   assign starved = (starve_q == STARVE_W'(STARVE_MAX));

   // The cycle carrying a ready pulse is a turnaround cycle: nothing is
   // granted, so a requester that re-asserts straight after its ready competes
   // fairly in the following cycle and the starvation count stays meaningful.
   assign turnaround  = m_ready | if_ready;
   assign data_grant  = in_idle & ~turnaround & m_ok & ~(if_ok & starved);
   assign fetch_grant = in_idle & ~turnaround & if_ok & ~data_grant;

   // A flush in the same cycle as the ack or timeout still drops the result.
   assign dropping  = drop_q | M_flush;
   assign timer_clr = in_idle | mem_ack | expired;

   mem_arb_timer u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clr),
      .enable  (~in_idle),
      .timeout (WAIT_W'(TIMEOUT)),
      .expired (expired)
   );

   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_be_d    = mem_be;
      m_rdata_d   = m_rdata;
      if_rdata_d  = if_rdata;
      m_ready_d   = 1'b0;
      if_ready_d  = 1'b0;
      bus_err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (data_grant) begin
               state_d     = D_WAIT;
               mem_req_d   = 1'b1;
               mem_we_d    = m_we;
               mem_addr_d  = m_addr;
               mem_wdata_d = m_wdata;
               mem_be_d    = m_be;
            end else if (fetch_grant) begin
               state_d     = I_WAIT;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               mem_be_d    = '0;
            end
         end
         D_WAIT: begin
            if (M_flush) drop_d = 1'b1;
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
               if (!dropping) begin
                  m_ready_d = 1'b1;
                  m_rdata_d = mem_rdata;
               end
            end else if (expired) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
               bus_err_d = 1'b1;
               if (!dropping) begin
                  m_ready_d = 1'b1;
                  m_rdata_d = '0;
               end
            end
         end
         I_WAIT: begin
            if (mem_ack) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               if_ready_d = 1'b1;
               if_rdata_d = mem_rdata;
            end else if (expired) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               bus_err_d  = 1'b1;
               if_ready_d = 1'b1;
               if_rdata_d = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            drop_d    = 1'b0;
         end
      endcase

      starve_d = starve_q;
      if (!if_req || fetch_grant) begin
         starve_d = '0;
      end else if (data_grant && if_ok && !starved) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         starve_q  <= '0;
         drop_q    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         m_rdata   <= '0;
         if_rdata  <= '0;
         m_ready   <= 1'b0;
         if_ready  <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         drop_q    <= drop_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_be    <= mem_be_d;
         m_rdata   <= m_rdata_d;
         if_rdata  <= if_rdata_d;
         m_ready   <= m_ready_d;
         if_ready  <= if_ready_d;
         bus_err   <= bus_err_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between instruction fetch (IF) and the MEM-stage load/store path of the 5-stage MIPS32 pipeline. Arbitrates requests, runs a req/ack handshake to memory, and produces the `F_stall`/`M_stall` signals that freeze the pipeline registers while an access is outstanding. It also drops results of flushed MEM accesses and returns an error if memory never acknowledges.

## Interface
- `TIMEOUT`, 255: cycles to wait for `mem_ack` before aborting; 1..255.
- `STARVE_MAX`, 4: consecutive data grants allowed while `if_req` is pending; after that, fetch wins once.

- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch request; held until `if_ready`.
- `if_addr` in 32: fetch address.
- `if_rdata` out 32: fetched word; valid when `if_ready`.
- `if_ready` out 1: one-cycle completion pulse.
- `m_req` in 1: MEM-stage access request; held until `m_ready`.
- `m_we` in 1: 1 = store.
- `m_addr` in 32: data address.
- `m_wdata` in 32: store data.
- `m_be` in 4: byte enables.
- `M_flush` in 1: MEM stage flushed this cycle.
- `m_rdata` out 32: load data; valid when `m_ready`.
- `m_ready` out 1: one-cycle completion pulse.
- `F_stall` out 1: `if_req & ~if_ready`, combinational.
- `M_stall` out 1: `m_req & ~m_ready & ~M_flush`, combinational.
- `bus_err` out 1: one-cycle pulse on timeout.
- `mem_req`, `mem_we` out 1 each: memory request and write enable.
- `mem_addr`, `mem_wdata` out 32 each: memory address and write data.
- `mem_be` out 4: memory byte enables.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in 32: memory read data.

## Operation
- **States:** IDLE, D_WAIT, I_WAIT.
- **IDLE arbitration:**
  - A requester whose `*_ready` is high this cycle is ignored, because its request is stale.
  - Data wins unless `starve_cnt == STARVE_MAX`. In that case fetch wins.
  - A data request with `M_flush` high is not granted.
- **Grant:** register `mem_req=1` and `mem_*` from the winner, then go to D_WAIT or I_WAIT. `mem_we`/`mem_wdata`/`mem_be` are 0 for fetch.
- **WAIT states:** `mem_*` are held stable and `wait_cnt` increments each cycle.
  - On `mem_ack`: register `mem_rdata` into `m_rdata` or `if_rdata` and pulse the matching ready.
  - In the same edge: `mem_req` goes to 0, `wait_cnt` goes to 0, and the state returns to IDLE.
- **Starvation counter:**
  - `starve_cnt` increments on each data grant made while `if_req` is pending.
  - It clears on any fetch grant, or when `if_req` is low.
  - It saturates at `STARVE_MAX`.
- **Flush:** `M_flush` during D_WAIT sets `drop`.
  - The access still completes on the memory side.
  - At ack, `m_ready` is suppressed and `m_rdata` is unchanged.
  - `drop` clears on return to IDLE.
- **Timeout:** when `wait_cnt == TIMEOUT` without ack:
  - `mem_req` goes to 0 and the state goes to IDLE.
  - `bus_err` pulses.
  - The owner's ready pulses with rdata = 0, unless `drop` is set.
- **`mem_ack` outside a WAIT state** is ignored.

## Timing
- **Reset:** every output is 0, state = IDLE, counters = 0, `drop` = 0.
- **Reset mid-transaction:** state returns to IDLE and `mem_req` = 0 after the edge. Memory must tolerate an abandoned request.
- **Latency:** request seen in IDLE at cycle 0 → `mem_req` at cycle 1 → ack at cycle k ≥ 1 → ready at cycle k+1. Minimum is 2 cycles (ack at cycle 1, ready at cycle 2).
- **Back-to-back:** a new request is granted no earlier than the cycle after its ready pulse, so there is at least one IDLE cycle between transactions.
- **Simultaneous `mem_ack` and timeout:** the ack wins and there is no `bus_err`.
- **Simultaneous `M_flush` and `mem_ack`:** the result is dropped.
- **Stall outputs** are combinational from the inputs and registered readies. There is no combinational path from `mem_ack` to any output.

## Structure
- **Package `mem_arb_pkg`:**
  - State encoding, with IDLE = 2'd0, D_WAIT = 2'd1, I_WAIT = 2'd2.
  - `WAIT_W = 8`.
  - The widths of `starve_cnt`.
- **Sub-module `mem_arb_timer`:** the `wait_cnt` counter. Inputs: clear, enable, `TIMEOUT`. Output: an `expired` flag.
- **Top module:** FSM, arbitration, output registers.

## Test plan
- **Data load:** `m_req`=1, `m_addr`=0x100, `mem_ack` at cycle 3 with `mem_rdata`=0xDEADBEEF → `m_ready` at cycle 4, `m_rdata`=0xDEADBEEF, `M_stall` high during cycles 0–3.
- **Conflict:** `if_req` and `m_req` both high in IDLE, `STARVE_MAX`=4 → data granted first; fetch granted after the data ready pulse; `if_ready` follows.
- **Starvation:** `m_req` re-asserted immediately after every ready, `if_req` held, ack after 1 cycle → exactly 4 data grants, then 1 fetch grant.
- **Flush:** `M_flush` pulsed in D_WAIT for a load, ack 2 cycles later → no `m_ready`; `m_rdata` keeps its old value; next IDLE arbitrates normally.
- **Timeout:** `TIMEOUT`=5, no ack → `mem_req` high for cycles 1–6; `bus_err` and `m_ready` pulse together with `m_rdata`=0; state IDLE.
- **Reset in I_WAIT:** `rst_n`=0 for 1 cycle → all outputs 0 the next cycle; a late `mem_ack` causes no ready pulse.
